// File: rtl/jedro_1_pkg.sv
// ---------------------------------------------------------------------------
// jedro_1_pkg
// Shared constants for the jedro_1 integer register file and its pending-write
// scoreboard.
//   DATA_WIDTH_DEF : default register width in bits
//   ADDR_WIDTH_DEF : default register address width
//   REG_ZERO       : architectural zero register index (x0)
//   num_regs()     : register count for a given address width
// ---------------------------------------------------------------------------
package jedro_1_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned REG_ZERO       = 0;

  function automatic int unsigned num_regs(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/jedro_1_scoreboard.sv
// ---------------------------------------------------------------------------
// jedro_1_scoreboard
// Pending-write tracker for the register file. Decode reserves a destination
// register on issue, writeback releases it.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset; drops every reservation
//   rsv_valid_i  reserve request from decode
//   rsv_addr_i   destination register to reserve
//   rsv_ready_o  reservation accepted this cycle (combinational)
//   wb_valid_i   writeback strobe
//   wb_addr_i    writeback address
//   busy_o       per-register pending-write flags (bit 0 is always 0)
//   pend_cnt_o   registered count of pending registers, saturating
//   wb_err_o     registered pulse: writeback hit a register that was not busy
// ---------------------------------------------------------------------------
module jedro_1_scoreboard
  import jedro_1_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       rsv_valid_i,
  input  logic [ADDR_WIDTH-1:0]      rsv_addr_i,
  output logic                       rsv_ready_o,
  input  logic                       wb_valid_i,
  input  logic [ADDR_WIDTH-1:0]      wb_addr_i,
  output logic [(1<<ADDR_WIDTH)-1:0] busy_o,
  output logic [ADDR_WIDTH:0]        pend_cnt_o,
  output logic                       wb_err_o
);

  localparam int                    NUM_REGS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_A   = ADDR_WIDTH'(REG_ZERO);
  localparam logic [ADDR_WIDTH:0]   CNT_MAX  = (ADDR_WIDTH+1)'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [ADDR_WIDTH:0] cnt_q;
  logic                err_q;

  logic rsv_nz;
  logic wb_nz;
  logic same_addr;
  logic rsv_acc;
  logic cnt_inc;
  logic cnt_dec;

  // Counter step that never wraps in either direction.
  function automatic logic [ADDR_WIDTH:0] sat_step(input logic [ADDR_WIDTH:0] cnt,
                                                   input logic              inc,
                                                   input logic              dec);
    logic [ADDR_WIDTH:0] nxt;
    nxt = cnt;
    if (inc && !dec && (cnt != CNT_MAX)) begin
      nxt = cnt + CNT_ONE;
    end else if (dec && !inc && (cnt != '0)) begin
      nxt = cnt - CNT_ONE;
    end
    return nxt;
  endfunction

  assign rsv_nz    = (rsv_addr_i != ZERO_A);
  assign wb_nz     = (wb_addr_i != ZERO_A);
  assign same_addr = wb_valid_i && (wb_addr_i == rsv_addr_i);

  // A busy register may be reserved again in the cycle its writeback lands.
  assign rsv_ready_o = rsv_valid_i && (!rsv_nz || !busy_q[rsv_addr_i] || same_addr);
  assign rsv_acc     = rsv_ready_o && rsv_nz;

  // The counter follows edge events on the busy bits; a reserve and release of
  // the same register in one cycle leaves it untouched.
  assign cnt_inc = rsv_acc && !busy_q[rsv_addr_i] && !same_addr;
  assign cnt_dec = wb_valid_i && wb_nz && busy_q[wb_addr_i] &&
                   !(rsv_acc && (rsv_addr_i == wb_addr_i));

  // Release first, then reserve, so a same-address collision stays busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid_i && wb_nz) begin
      busy_d[wb_addr_i] = 1'b0;
    end
    if (rsv_acc) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= sat_step(cnt_q, cnt_inc, cnt_dec);
      err_q  <= wb_valid_i && wb_nz && !busy_q[wb_addr_i];
    end
  end

  assign busy_o     = busy_q;
  assign pend_cnt_o = cnt_q;
  assign wb_err_o   = err_q;

endmodule

// File: rtl/jedro_1_regfile_sb.sv
// ---------------------------------------------------------------------------
// jedro_1_regfile_sb
// Integer register file for the pipelined jedro core with NUM_RD combinational
// read ports, one writeback port and a pending-write scoreboard.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset; clears data and reservations
//   rd_addr_i    packed read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data_o    packed read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rd_busy_o    port k addresses a register with an unsatisfied pending write
//   rsv_valid_i  reserve request from decode
//   rsv_addr_i   destination register to reserve
//   rsv_ready_o  reservation accepted this cycle
//   wb_valid_i   writeback strobe
//   wb_addr_i    writeback address
//   wb_data_i    writeback data
//   pend_cnt_o   number of registers currently busy (registered)
//   wb_err_o     registered pulse: writeback to a register that was not busy
// ---------------------------------------------------------------------------
module jedro_1_regfile_sb
  import jedro_1_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data_o,
  output logic [NUM_RD-1:0]            rd_busy_o,
  input  logic                         rsv_valid_i,
  input  logic [ADDR_WIDTH-1:0]        rsv_addr_i,
  output logic                         rsv_ready_o,
  input  logic                         wb_valid_i,
  input  logic [ADDR_WIDTH-1:0]        wb_addr_i,
  input  logic [DATA_WIDTH-1:0]        wb_data_i,
  output logic [ADDR_WIDTH:0]          pend_cnt_o,
  output logic                         wb_err_o
);

  localparam int                    NUM_REGS  = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_A    = ADDR_WIDTH'(REG_ZERO);
  localparam bit                    BYPASS_EN = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic                  wb_we;

  assign wb_we = wb_valid_i && (wb_addr_i != ZERO_A);

  jedro_1_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rsv_valid_i (rsv_valid_i),
    .rsv_addr_i  (rsv_addr_i),
    .rsv_ready_o (rsv_ready_o),
    .wb_valid_i  (wb_valid_i),
    .wb_addr_i   (wb_addr_i),
    .busy_o      (busy),
    .pend_cnt_o  (pend_cnt_o),
    .wb_err_o    (wb_err_o)
  );

  // x0 is never written, so its entry holds the reset value of zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_we) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic                  hit;

    assign addr = rd_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    // A same-cycle writeback both supplies the data and satisfies the hazard.
    assign hit  = BYPASS_EN && wb_we && (wb_addr_i == addr);

    assign rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = (addr == ZERO_A) ? '0 :
                                                   hit              ? wb_data_i :
                                                                      regs_q[addr];
    assign rd_busy_o[k] = busy[addr] && !hit;
  end

endmodule

// File: tb/tb_jedro_1_regfile_sb.sv
module tb_jedro_1_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  ra0 = '0;
  logic [4:0]  ra1 = '0;
  logic [9:0]  rd_addr;
  logic        rsv_v = 1'b0;
  logic [4:0]  rsv_a = '0;
  logic        wb_v  = 1'b0;
  logic [4:0]  wb_a  = '0;
  logic [31:0] wb_d  = '0;

  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic        rdy_b, rdy_n;
  logic [5:0]  pend_b, pend_n;
  logic        err_b, err_n;

  assign rd_addr = {ra1, ra0};

  always #5 clk = ~clk;

  jedro_1_regfile_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .BYPASS(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b),
    .rd_busy_o(rd_busy_b), .rsv_valid_i(rsv_v), .rsv_addr_i(rsv_a),
    .rsv_ready_o(rdy_b), .wb_valid_i(wb_v), .wb_addr_i(wb_a), .wb_data_i(wb_d),
    .pend_cnt_o(pend_b), .wb_err_o(err_b));

  jedro_1_regfile_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .BYPASS(0)) dut_n (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_n),
    .rd_busy_o(rd_busy_n), .rsv_valid_i(rsv_v), .rsv_addr_i(rsv_a),
    .rsv_ready_o(rdy_n), .wb_valid_i(wb_v), .wb_addr_i(wb_a), .wb_data_i(wb_d),
    .pend_cnt_o(pend_n), .wb_err_o(err_n));

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: architectural contents, pending set and event counter.
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  int          m_cnt;
  bit          m_err;

  typedef struct {
    int          rv, ra, wv, wa;
    logic [31:0] wd;
    int          a0, a1;
    logic [31:0] d0;
    int          b0, rdy, cnt, err;
    logic [31:0] nd0;
    int          nb0;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  function automatic logic [31:0] m_rd(input logic [4:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && wb_v && wb_a == a) return wb_d;
    return m_regs[a];
  endfunction

  function automatic bit m_bsy(input logic [4:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && wb_v && wb_a == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic bit m_ready();
    return rsv_v && (rsv_a == 0 || !m_busy[rsv_a] || (wb_v && wb_a == rsv_a));
  endfunction

  task automatic m_step();
    bit rdy, inc, dec;
    rdy   = m_ready();
    inc   = rdy && rsv_a != 0 && !m_busy[rsv_a] && !(wb_v && wb_a == rsv_a);
    dec   = wb_v && wb_a != 0 && m_busy[wb_a] && !(rdy && rsv_a == wb_a);
    m_err = wb_v && wb_a != 0 && !m_busy[wb_a];
    if (wb_v && wb_a != 0) begin
      m_regs[wb_a] = wb_d;
      m_busy[wb_a] = 1'b0;
    end
    if (rdy && rsv_a != 0) m_busy[rsv_a] = 1'b1;
    if (inc && !dec && m_cnt < 31) m_cnt++;
    else if (dec && !inc && m_cnt > 0) m_cnt--;
  endtask

  task automatic drive(input int rv_, input int ra_, input int wv_, input int wa_,
                       input logic [31:0] wd_, input int a0_, input int a1_);
    rsv_v = (rv_ != 0);
    rsv_a = 5'(ra_);
    wb_v  = (wv_ != 0);
    wb_a  = 5'(wa_);
    wb_d  = wd_;
    ra0   = 5'(a0_);
    ra1   = 5'(a1_);
  endtask

  task automatic check_comb_model();
    logic [4:0] a;
    for (int k = 0; k < 2; k++) begin
      a = (k == 0) ? ra0 : ra1;
      chk($sformatf("rd_data_byp[%0d]", k), rd_data_b[k*32 +: 32], m_rd(a, 1'b1));
      chk($sformatf("rd_busy_byp[%0d]", k), 32'(rd_busy_b[k]), 32'(m_bsy(a, 1'b1)));
      chk($sformatf("rd_data_nobyp[%0d]", k), rd_data_n[k*32 +: 32], m_rd(a, 1'b0));
      chk($sformatf("rd_busy_nobyp[%0d]", k), 32'(rd_busy_n[k]), 32'(m_bsy(a, 1'b0)));
    end
    chk("rsv_ready_byp", 32'(rdy_b), 32'(m_ready()));
    chk("rsv_ready_nobyp", 32'(rdy_n), 32'(m_ready()));
  endtask

  task automatic check_reg_model();
    chk("pend_cnt_byp", 32'(pend_b), 32'(m_cnt));
    chk("pend_cnt_nobyp", 32'(pend_n), 32'(m_cnt));
    chk("wb_err_byp", 32'(err_b), 32'(m_err));
    chk("wb_err_nobyp", 32'(err_n), 32'(m_err));
  endtask

  // Inputs change 1 time unit after a rising edge; combinational outputs are
  // sampled 3 units later, registered outputs 1 unit after the next edge.
  task automatic cycle(input int rv_, input int ra_, input int wv_, input int wa_,
                       input logic [31:0] wd_, input int a0_, input int a1_);
    drive(rv_, ra_, wv_, wa_, wd_, a0_, a1_);
    #3;
    check_comb_model();
    m_step();
    @(posedge clk);
    #1;
    check_reg_model();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1, 3, 0, 0, 0,          3, 0, 0,          0, 1, 1, 0, 0,      0};
    tbl[1]  = '{0, 0, 0, 0, 0,          3, 0, 0,          1, 0, 1, 0, 0,      1};
    tbl[2]  = '{0, 0, 1, 3, 'h1234,     3, 0, 'h1234,     0, 0, 0, 0, 0,      1};
    tbl[3]  = '{0, 0, 0, 0, 0,          3, 0, 'h1234,     0, 0, 0, 0, 'h1234, 0};
    tbl[4]  = '{1, 7, 0, 0, 0,          7, 3, 0,          0, 1, 1, 0, 0,      0};
    tbl[5]  = '{1, 7, 0, 0, 0,          7, 3, 0,          1, 0, 1, 0, 0,      1};
    tbl[6]  = '{1, 7, 0, 0, 0,          7, 3, 0,          1, 0, 1, 0, 0,      1};
    tbl[7]  = '{1, 7, 0, 0, 0,          7, 3, 0,          1, 0, 1, 0, 0,      1};
    tbl[8]  = '{1, 7, 1, 7, 'hA5A5,     7, 7, 'hA5A5,     0, 1, 1, 0, 0,      1};
    tbl[9]  = '{0, 0, 0, 0, 0,          7, 0, 'hA5A5,     1, 0, 1, 0, 'hA5A5, 1};
    tbl[10] = '{1, 0, 0, 0, 0,          0, 0, 0,          0, 1, 1, 0, 0,      0};
    tbl[11] = '{0, 0, 1, 0, 'hFFFFFFFF, 0, 0, 0,          0, 0, 1, 0, 0,      0};
    tbl[12] = '{0, 0, 0, 0, 0,          0, 0, 0,          0, 0, 1, 0, 0,      0};
    tbl[13] = '{0, 0, 1, 9, 'h55,       9, 0, 'h55,       0, 0, 1, 1, 0,      0};
    tbl[14] = '{0, 0, 0, 0, 0,          9, 0, 'h55,       0, 0, 1, 0, 'h55,   0};
    tbl[15] = '{0, 0, 1, 7, 'h77,       7, 9, 'h77,       0, 0, 0, 0, 'hA5A5, 1};

    m_reset();

    // Reset state while rst is held from time zero.
    #12;
    chk("reset_pend", 32'(pend_b), 32'd0);
    chk("reset_err", 32'(err_b), 32'd0);
    chk("reset_rd0", rd_data_b[31:0], 32'd0);
    chk("reset_busy", 32'(rd_busy_b), 32'd0);
    #5 rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors: RAW bypass, WAW refusal, x0 handling, error pulse.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rv, tbl[i].ra, tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].a0, tbl[i].a1);
      #3;
      chk($sformatf("vec%0d_rd0", i), rd_data_b[31:0], tbl[i].d0);
      chk($sformatf("vec%0d_busy0", i), 32'(rd_busy_b[0]), 32'(tbl[i].b0));
      chk($sformatf("vec%0d_ready", i), 32'(rdy_b), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_rd0_nobyp", i), rd_data_n[31:0], tbl[i].nd0);
      chk($sformatf("vec%0d_busy0_nobyp", i), 32'(rd_busy_n[0]), 32'(tbl[i].nb0));
      check_comb_model();
      m_step();
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_pend", i), 32'(pend_b), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_err", i), 32'(err_b), 32'(tbl[i].err));
      check_reg_model();
    end

    // Saturation: reserve every non-zero register back to back.
    for (int i = 1; i < 32; i++) begin
      cycle(1, i, 0, 0, 0, i, 0);
    end
    chk("sat_pend_full", 32'(pend_b), 32'd31);
    cycle(1, 0, 1, 31, 32'hCAFE0031, 31, 0);
    chk("sat_pend_after_wb", 32'(pend_b), 32'd30);

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      cycle(int'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom,
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    end

    // Asynchronous reset mid-operation with x5 busy and holding 0xDEADBEEF.
    cycle(1, 5, 1, 5, 32'hDEADBEEF, 5, 5);
    drive(0, 0, 0, 0, 0, 5, 5);
    #3;
    check_comb_model();
    chk("pre_rst_x5_data", rd_data_b[31:0], 32'hDEADBEEF);
    chk("pre_rst_x5_busy", 32'(rd_busy_b[0]), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_rd0", rd_data_b[31:0], 32'd0);
    chk("async_rst_rd1", rd_data_b[63:32], 32'd0);
    chk("async_rst_busy", 32'(rd_busy_b), 32'd0);
    chk("async_rst_pend", 32'(pend_b), 32'd0);
    chk("async_rst_err", 32'(err_b), 32'd0);
    chk("async_rst_rd0_nobyp", rd_data_n[31:0], 32'd0);
    chk("async_rst_pend_nobyp", 32'(pend_n), 32'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(0, 0, 0, 0, 0, 5, 3);
    cycle(1, 5, 0, 0, 0, 5, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
